// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-port req/ack arbiter in front of a single-port data RAM
module ram_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int READ_LAT  = 1,
    parameter int FIXED_PRI = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              we0,
    input  logic [31:0]       wdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              we1,
    input  logic [31:0]       wdata1,
    output logic              ack1,
    output logic [31:0]       rdata,
    output logic              err,
    output logic              busy,
    output logic              gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_cs,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_ACK} state_t;

    localparam logic [1:0] WAIT_INIT = 2'((READ_LAT > 0) ? READ_LAT - 1 : 0);

    state_t            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              we_q, we_d;
    logic              mis_q, mis_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_cs_q, mem_cs_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic              win;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic [31:0]       sel_wdata;
    logic              sel_mis;

    // Round-robin favours the port that was not granted last; gnt resets to 1 so port 0 goes first.
    always_comb begin
        win = 1'b0;
        if (FIXED_PRI != 0) begin
            win = !req0;
        end else if (req0 && req1) begin
            win = !gnt_q;
        end else begin
            win = req1;
        end
    end

    assign sel_addr  = win ? addr1  : addr0;
    assign sel_we    = win ? we1    : we0;
    assign sel_wdata = win ? wdata1 : wdata0;
    assign sel_mis   = (sel_addr[1:0] != 2'b00);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        we_d        = we_q;
        mis_d       = mis_q;
        cnt_d       = cnt_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_cs_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    gnt_d       = win;
                    we_d        = sel_we;
                    mis_d       = sel_mis;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    mem_cs_d    = !sel_mis;
                    mem_we_d    = !sel_mis && sel_we;
                    state_d     = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (mis_q || we_q || READ_LAT == 0) begin
                    err_d   = mis_q;
                    ack0_d  = !gnt_q;
                    ack1_d  = gnt_q;
                    state_d = S_ACK;
                    if (!mis_q && !we_q) begin
                        rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d   = WAIT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 2'd0) begin
                    rdata_d = mem_rdata;
                    ack0_d  = !gnt_q;
                    ack1_d  = gnt_q;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            gnt_q       <= 1'b1;
            we_q        <= 1'b0;
            mis_q       <= 1'b0;
            cnt_q       <= 2'd0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'd0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_cs_q    <= 1'b0;
            mem_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            we_q        <= we_d;
            mis_q       <= mis_d;
            cnt_q       <= cnt_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_cs_q    <= mem_cs_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign busy      = (state_q != S_IDLE);
    assign gnt       = gnt_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_cs    = mem_cs_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - randomized transaction-level check of ram_port_arbiter in three configurations
module tb_ram_port_arbiter;

    logic CLK;
    logic RST;
    int   checks   = 0;
    int   failures = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int inst, input int idx);
        return (32'(idx) * 32'h9E37_79B1) ^ 32'(inst * 32'h0101_0101);
    endfunction

    // 0: round-robin READ_LAT=1, 1: fixed priority READ_LAT=0, 2: round-robin READ_LAT=3
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int FP  = (g == 1) ? 1 : 0;
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        localparam int PI  = (LAT > 0) ? LAT - 1 : 0;

        logic        req0, we0, ack0, req1, we1, ack1;
        logic        err, busy, gnt, mem_we, mem_cs;
        logic [31:0] addr0, addr1, wdata0, wdata1, rdata;
        logic [31:0] mem_addr, mem_wdata, mem_rdata;

        ram_port_arbiter #(.ADDR_W(32), .READ_LAT(LAT), .FIXED_PRI(FP)) u_dut (
            .CLK(CLK), .RST(RST),
            .req0(req0), .addr0(addr0), .we0(we0), .wdata0(wdata0), .ack0(ack0),
            .req1(req1), .addr1(addr1), .we1(we1), .wdata1(wdata1), .ack1(ack1),
            .rdata(rdata), .err(err), .busy(busy), .gnt(gnt),
            .mem_addr(mem_addr), .mem_we(mem_we), .mem_cs(mem_cs),
            .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
        );

        logic [31:0] ram [0:4095];
        logic [31:0] pipe [0:2];

        initial begin
            for (int i = 0; i < 4096; i++) ram[i] <= init_word(g, i);
        end

        always @(posedge CLK) begin
            if (mem_cs && mem_we) ram[mem_addr[13:2]] <= mem_wdata;
            pipe[0] <= ram[mem_addr[13:2]];
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end

        assign mem_rdata = (LAT == 0) ? ram[mem_addr[13:2]] : pipe[PI];

        bit          rq [2];
        bit          wr [2];
        logic [31:0] ad [2];
        logic [31:0] wd [2];
        int          gap [2];

        assign req0 = rq[0];
        assign we0 = wr[0];
        assign addr0 = ad[0];
        assign wdata0 = wd[0];
        assign req1 = rq[1];
        assign we1 = wr[1];
        assign addr1 = ad[1];
        assign wdata1 = wd[1];

        // Transaction model: one access at a time, ack at grant+2 (+LAT for aligned reads).
        logic [31:0] sh [0:4095];
        bit          m_busy, m_port, m_we, m_mis, gnt_m, win, done, was_idle, exp_cs;
        int          t_g, t_a, n;
        logic [31:0] m_addr, m_wdata, rd_exp;
        string       p;

        initial begin
            p = $sformatf("i%0d_", g);
            for (int i = 0; i < 4096; i++) sh[i] = init_word(g, i);
            for (int k = 0; k < 2; k++) begin
                rq[k] = 1'b0; wr[k] = 1'b0; ad[k] = 32'd0; wd[k] = 32'd0; gap[k] = 0;
            end
            m_busy = 1'b0; gnt_m = 1'b1; rd_exp = 32'd0; n = 0; t_g = 0; t_a = 0;
            forever begin
                @(negedge CLK);
                if (!RST) begin
                    m_busy = 1'b0; gnt_m = 1'b1; rd_exp = 32'd0;
                    for (int k = 0; k < 2; k++) begin
                        rq[k] = 1'b0;
                        gap[k] = $urandom_range(0, 2);
                    end
                    chk({p, "rst_ctl"}, {58'd0, ack0, ack1, err, busy, mem_we, mem_cs}, 64'd0);
                    chk({p, "rst_gnt"}, 64'(gnt), 64'd1);
                    chk({p, "rst_rdata"}, 64'(rdata), 64'd0);
                    chk({p, "rst_mem"}, {mem_addr, mem_wdata}, 64'd0);
                end else begin
                    exp_cs = m_busy && (n == t_g + 1) && !m_mis;
                    done   = m_busy && (n == t_a);
                    chk({p, "cs"}, 64'(mem_cs), 64'(exp_cs));
                    chk({p, "we"}, 64'(mem_we), 64'(exp_cs && m_we));
                    if (exp_cs) chk({p, "maddr"}, 64'(mem_addr), 64'(m_addr));
                    if (exp_cs && m_we) chk({p, "mwdata"}, 64'(mem_wdata), 64'(m_wdata));
                    chk({p, "ack0"}, 64'(ack0), 64'(done && !m_port));
                    chk({p, "ack1"}, 64'(ack1), 64'(done && m_port));
                    chk({p, "busy"}, 64'(busy), 64'(m_busy));
                    chk({p, "gnt"}, 64'(gnt), 64'(gnt_m));
                    if (done && !m_mis && m_we) sh[m_addr[13:2]] = m_wdata;
                    if (done && !m_mis && !m_we) rd_exp = sh[m_addr[13:2]];
                    chk({p, "err"}, 64'(err), 64'(done && m_mis));
                    chk({p, "rdata"}, 64'(rdata), 64'(rd_exp));
                    was_idle = !m_busy;
                    if (done) m_busy = 1'b0;
                    for (int k = 0; k < 2; k++) begin
                        if (done && (int'(m_port) == k)) begin
                            rq[k]  = 1'b0;
                            gap[k] = $urandom_range(0, 3);
                        end
                        if (!rq[k]) begin
                            if (gap[k] == 0) begin
                                rq[k] = 1'b1;
                                wr[k] = 1'($urandom_range(0, 1));
                                ad[k] = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 63)) << 2);
                                if ($urandom_range(0, 7) == 0) ad[k][1:0] = 2'($urandom_range(1, 3));
                                wd[k] = $urandom;
                            end else begin
                                gap[k]--;
                            end
                        end
                    end
                    if (was_idle && (rq[0] || rq[1])) begin
                        if (FP != 0) win = !rq[0];
                        else if (rq[0] && rq[1]) win = !gnt_m;
                        else win = rq[1];
                        m_busy  = 1'b1;
                        m_port  = win;
                        m_addr  = ad[win];
                        m_we    = wr[win];
                        m_wdata = wd[win];
                        m_mis   = (m_addr[1:0] != 2'b00);
                        t_g     = n;
                        t_a     = n + 2 + ((m_mis || m_we) ? 0 : LAT);
                        gnt_m   = win;
                    end
                end
                n++;
            end
        end
    end

    bit found;
    bit prev_rd;

    initial begin
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        #1 RST = 1'b1;
        repeat (3000) @(negedge CLK);

        // Pulse reset while instance 0 (READ_LAT=1) sits in WAIT.
        found = 1'b0;
        prev_rd = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge CLK);
            if (prev_rd) found = 1'b1;
            else prev_rd = g_dut[0].mem_cs && !g_dut[0].mem_we;
        end
        chk("wait_found", 64'(found), 64'd1);
        if (found) begin
            #1 RST = 1'b0;
            #1;
            chk("rst_wait_ctl", {58'd0, g_dut[0].ack0, g_dut[0].ack1, g_dut[0].err,
                                 g_dut[0].busy, g_dut[0].mem_we, g_dut[0].mem_cs}, 64'd0);
            chk("rst_wait_gnt", 64'(g_dut[0].gnt), 64'd1);
            chk("rst_wait_rdata", 64'(g_dut[0].rdata), 64'd0);
            @(negedge CLK);
            #1 RST = 1'b1;
        end

        repeat (2000) @(negedge CLK);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
